// File: rtl/ecc_secded_pipe.sv
// Two-stage pipelined Hamming SEC decoder with valid/ready stream and saturating error counters.
// Define ECC_DED_EN to use the overall parity bit for double-error detection (SEC-DED).
module ecc_secded_pipe #(
    parameter int  DATA_W = 32,
    parameter int  CNT_W  = 16,
    localparam int CHK_W  = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    input  logic              in_par,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_syndrome,
    output logic              out_ce,
    output logic              out_ue,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count
);

    localparam int CW_N = DATA_W + CHK_W;

    // Codeword position of data bit j: the j-th non-power-of-two position counting from 1.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int k = 1; k <= 128; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (cnt == j) pos = k;
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic pos_bit(input int j, input int i);
        int p;
        p = data_pos(j);
        return p[i];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic [CHK_W-1:0]  chk_calc;
    logic [DATA_W-1:0] data_p1, data_p2, data_fix;
    logic [CHK_W-1:0]  syn_p1, syn_p2;
    logic              corr_p1;
    logic              vld_p1, vld_p2;
    logic              ce_p2, ue_p2, ce_d, ue_d, sec;
    logic              en_p1, en_p2;
    logic              par_d;

    // Stage 0: recompute check bits and overall parity
    always_comb begin
        chk_calc = '0;
        for (int j = 0; j < DATA_W; j++) begin
            for (int i = 0; i < CHK_W; i++) begin
                if (pos_bit(j, i)) chk_calc[i] = chk_calc[i] ^ in_data[j];
            end
        end
    end

`ifdef ECC_DED_EN
    assign par_d = in_par ^ (^in_data) ^ (^in_chk);
    logic par_p1;
`else
    assign par_d = 1'b0;
    logic unused_par;
    assign unused_par = in_par ^ par_d;
`endif

    assign en_p2    = !vld_p2 || out_ready;
    assign en_p1    = !vld_p1 || en_p2;
    assign in_ready = en_p1;

    // Stage 1 boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else if (en_p1) vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (en_p1 && in_valid) begin
            data_p1 <= in_data;
            syn_p1  <= in_chk ^ chk_calc;
            corr_p1 <= corr_en;
`ifdef ECC_DED_EN
            par_p1  <= par_d;
`endif
        end
    end

    always_comb begin
        data_fix = data_p1;
        ce_d     = 1'b0;
        ue_d     = 1'b0;
`ifdef ECC_DED_EN
        sec = 1'b0;
        if (syn_p1 == '0) ce_d = par_p1;
        else if (!par_p1) ue_d = 1'b1;
        else sec = 1'b1;
`else
        sec = (syn_p1 != '0);
`endif
        if (sec) begin
            if (int'(syn_p1) > CW_N) ue_d = 1'b1;
            else ce_d = 1'b1;
        end
        if (sec && corr_p1) begin
            for (int j = 0; j < DATA_W; j++) begin
                if (data_pos(j) == int'(syn_p1)) data_fix[j] = ~data_p1[j];
            end
        end
    end

    // Stage 2 boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            syn_p2  <= '0;
            ce_p2   <= 1'b0;
            ue_p2   <= 1'b0;
        end else if (en_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= data_fix;
                syn_p2  <= syn_p1;
                ce_p2   <= ce_d;
                ue_p2   <= ue_d;
            end
        end
    end

    assign out_valid    = vld_p2;
    assign out_data     = data_p2;
    assign out_syndrome = syn_p2;
    assign out_ce       = ce_p2;
    assign out_ue       = ue_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (cnt_clr) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (vld_p2 && out_ready) begin
            if (ce_p2) ce_count <= sat_inc(ce_count);
            if (ue_p2) ue_count <= sat_inc(ue_count);
        end
    end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe (DATA_W=32, CNT_W=4).
module tb_ecc_secded_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_par, corr_en;
    logic [31:0] in_data;
    logic [5:0]  in_chk;
    logic        out_valid, out_ready, out_ce, out_ue, cnt_clr;
    logic [31:0] out_data;
    logic [5:0]  out_syndrome;
    logic [3:0]  ce_count, ue_count;

    int checks = 0;
    int errors = 0;

    ecc_secded_pipe #(.DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chk(in_chk), .in_par(in_par), .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome),
        .out_ce(out_ce), .out_ue(out_ue),
        .cnt_clr(cnt_clr), .ce_count(ce_count), .ue_count(ue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One word through an empty pipeline with out_ready held high.
    task automatic word(input string tag, input logic [31:0] d, input logic [5:0] c,
                        input logic p, input logic ce_en, input logic [31:0] exp_d,
                        input logic [5:0] exp_s, input logic exp_ce, input logic exp_ue);
        in_valid = 1'b1; in_data = d; in_chk = c; in_par = p; corr_en = ce_en;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
        chk({tag, "_syn"}, 64'(out_syndrome), 64'(exp_s));
        chk({tag, "_ce"}, 64'(out_ce), 64'(exp_ce));
        chk({tag, "_ue"}, 64'(out_ue), 64'(exp_ue));
        @(posedge clk); #1;
        chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    logic [31:0] wd [4];
    logic [5:0]  wc [4];
    logic        wp [4];
    logic [31:0] got [$];
    int          idx;
    logic        acc;
    int          exp_ce_cnt, exp_ue_cnt;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_chk = '0; in_par = 1'b0;
        corr_en = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_ce_count", 64'(ce_count), 64'd0);
        chk("rst_ue_count", 64'(ue_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        word("clean", 32'h0, 6'd0, 1'b0, 1'b1, 32'h0, 6'd0, 1'b0, 1'b0);
        word("d0_corr", 32'h1, 6'd0, 1'b0, 1'b1, 32'h0, 6'd3, 1'b1, 1'b0);
        word("d0_nocorr", 32'h1, 6'd0, 1'b0, 1'b0, 32'h1, 6'd3, 1'b1, 1'b0);
        word("chk2_err", 32'h0, 6'b000100, 1'b0, 1'b1, 32'h0, 6'd4, 1'b1, 1'b0);
        word("syn_oor", 32'h0, 6'b111111, 1'b0, 1'b1, 32'h0, 6'd63, 1'b0, 1'b1);
`ifdef ECC_DED_EN
        word("double", 32'h3, 6'd0, 1'b0, 1'b1, 32'h3, 6'd6, 1'b0, 1'b1);
        exp_ce_cnt = 3; exp_ue_cnt = 2;
`else
        word("double", 32'h3, 6'd0, 1'b0, 1'b1, 32'h7, 6'd6, 1'b1, 1'b0);
        exp_ce_cnt = 4; exp_ue_cnt = 1;
`endif
        chk("ce_count_acc", 64'(ce_count), 64'(exp_ce_cnt));
        chk("ue_count_acc", 64'(ue_count), 64'(exp_ue_cnt));

        // Backpressure: valid codewords, consumer stalled for 5 cycles
        wd[0] = 32'h0; wc[0] = 6'd0; wp[0] = 1'b0;
        wd[1] = 32'h1; wc[1] = 6'd3; wp[1] = 1'b1;
        wd[2] = 32'h2; wc[2] = 6'd5; wp[2] = 1'b1;
        wd[3] = 32'h3; wc[3] = 6'd6; wp[3] = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 5) begin
                chk("bp_accepted", 64'(idx), 64'd2);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_hold_vld", 64'(out_valid), 64'd1);
                chk("bp_hold_data", 64'(out_data), 64'(wd[0]));
                out_ready = 1'b1;
            end
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_data = wd[idx]; in_chk = wc[idx]; in_par = wp[idx]; corr_en = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_data);
            @(posedge clk); #1;
            if (acc) idx++;
            if (got.size() == 4) break;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk($sformatf("bp_word%0d", k), 64'(got[k]), 64'(wd[k]));
        end
        repeat (3) @(posedge clk);
        #1;

        // Counter saturation and clear priority
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_ce", 64'(ce_count), 64'd0);
        chk("clr_ue", 64'(ue_count), 64'd0);
        in_data = 32'h1; in_chk = 6'd0; in_par = 1'b0; corr_en = 1'b1;
        in_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_ce", 64'(ce_count), 64'd15);
        chk("sat_ue", 64'(ue_count), 64'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clr_hs_vld", 64'(out_valid && out_ce), 64'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_wins", 64'(ce_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined Hamming ECC decoder. Successor to the fixed 32-bit combinational single-error corrector in the benchmark set.
- Takes a data word, its Hamming check bits and an optional overall parity bit. Returns corrected data, the syndrome and error flags through a valid/ready stream.
- Keeps saturating correctable and uncorrectable error counters for status readback.
- Sits between a memory/link read port and the consumer.

Parameters:
- DATA_W, 32: data width, 4..64.
- CNT_W, 16: width of each error counter.
- CHK_W: derived localparam, not overridable. Smallest r with 2^r >= DATA_W+r+1; 6 for DATA_W=32.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  decoder accepts the input word this cycle.
- in_data  in  DATA_W  received data.
- in_chk  in  CHK_W  received Hamming check bits.
- in_par  in  1  received overall parity bit; ignored unless ECC_DED_EN is defined.
- corr_en  in  1  sampled with the input word. 1 = apply correction; 0 = pass data unmodified, flags still reported.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  corrected data.
- out_syndrome  out  CHK_W  computed syndrome.
- out_ce  out  1  correctable error detected.
- out_ue  out  1  uncorrectable error detected.
- cnt_clr  in  1  synchronous clear of both counters.
- ce_count  out  CNT_W  saturating count of correctable errors.
- ue_count  out  CNT_W  saturating count of uncorrectable errors.

Behaviour:
- Code layout:
  - Codeword positions run 1..DATA_W+CHK_W.
  - Check bit i sits at position 2^i.
  - Data bits fill the non-power-of-two positions in ascending order: bit0→3, bit1→5, bit2→6, bit3→7, bit4→9, and so on.
  - Recomputed check bit i = XOR of the data bits whose position has bit i set.
- Syndrome s = in_chk XOR recomputed check bits.
- Without DED:
  - s==0: no error.
  - s is a data position: ce=1; that data bit is flipped if corr_en.
  - s is a power of two: ce=1; data unchanged.
  - s > DATA_W+CHK_W: ue=1; data unchanged.
- ce and ue are never both 1.
- Pipeline: two register stages.
  - S1 registers data, syndrome and corr_en.
  - S2 registers corrected data and flags.
  - Latency is exactly 2 cycles from input handshake to out_valid when out_ready is held 1. Throughput is 1 word/cycle.
- Stage advance rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S1 advances.
  - in_ready = !S1_valid || S2 load enable. A combinational path out_ready→in_ready is permitted.
- Output stability: while out_valid=1 and out_ready=0, all out_* are held stable. No word is dropped, duplicated or reordered.
- Counters:
  - On each output handshake (out_valid && out_ready), ce_count increments if out_ce and ue_count increments if out_ue.
  - Each counter saturates at all-ones.
  - cnt_clr wins over a same-cycle increment; the result is 0.
- Reset:
  - out_valid=0, out_data/out_syndrome/out_ce/out_ue=0, both counters=0.
  - in_ready=1 from the first cycle after reset release.
  - Reset asserted mid-operation discards in-flight words.

Optional Feature:
- Macro ECC_DED_EN.
- Defined:
  - Overall parity p = in_par XOR all in_data bits XOR all in_chk bits.
  - s!=0 and p=1: single error, handled as in the SEC rules; an out-of-range s is still ue.
  - s!=0 and p=0: ue=1, no correction.
  - s==0 and p=1: parity-bit error, ce=1, data unchanged.
- Not defined: in_par is ignored and pure SEC rules apply.

Test Plan:
- DATA_W=32, in_data=0, in_chk=0, in_par=0 → out_data=0, syndrome=0, ce=0, ue=0, two cycles after the handshake.
- in_data=0x00000001, in_chk=0, corr_en=1 → syndrome=6'd3, out_data=0, ce=1. Same stimulus with corr_en=0 → out_data=0x1, ce=1.
- in_data=0, in_chk=6'b000100 → syndrome=4, out_data=0, ce=1. in_chk=6'b111111 → syndrome=63, ue=1, data unchanged.
- in_data=0x3, in_chk=0, in_par=0:
  - With ECC_DED_EN → syndrome=6, ue=1, out_data=0x3.
  - Without it → out_data=0x7 (miscorrection), ce=1.
- Send 4 words with out_ready=0 for 5 cycles → in_ready drops after 2 accepted; after out_ready=1, all 4 words emerge in order, unchanged.
- CNT_W=4: 20 consecutive single-error words → ce_count=15. cnt_clr asserted together with a ce handshake → ce_count=0.
